// File: rtl/fpmul_bus_master.sv
// Bus initiator for the memory-mapped FP multiplier: writes A, B and go, polls done,
// reads the product, clears go and hands the result back on a valid/ready port.
module fpmul_bus_master #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_timeout,
  output logic             bus_we,
  output logic [1:0]       bus_addr,
  output logic [WIDTH-1:0] bus_wd,
  input  logic [WIDTH-1:0] bus_rd,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_A   = 3'd1,
    ST_WR_B   = 3'd2,
    ST_WR_GO  = 3'd3,
    ST_POLL   = 3'd4,
    ST_RD_RES = 3'd5,
    ST_CLR_GO = 3'd6,
    ST_RESP   = 3'd7
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] op_a_r, op_a_s;
  logic [WIDTH-1:0] op_b_r, op_b_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic [CW-1:0]    cnt_r, cnt_s, cnt_inc_s;
  logic             timeout_r, timeout_s;

  logic             req_ready_r, busy_r, rsp_valid_r, bus_we_r;
  logic [1:0]       bus_addr_r;
  logic [WIDTH-1:0] bus_wd_r;
  logic             bus_we_s;
  logic [1:0]       bus_addr_s;
  logic [WIDTH-1:0] bus_wd_s;

  // Next-state and datapath update logic.
  always_comb begin
    state_s   = state_r;
    op_a_s    = op_a_r;
    op_b_s    = op_b_r;
    result_s  = result_r;
    cnt_s     = cnt_r;
    timeout_s = timeout_r;
    cnt_inc_s = cnt_r + CW'(1);
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready_r) begin
          op_a_s    = req_a;
          op_b_s    = req_b;
          cnt_s     = {CW{1'b0}};
          timeout_s = 1'b0;
          state_s   = ST_WR_A;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR_A:  state_s = ST_WR_B;
      ST_WR_B:  state_s = ST_WR_GO;
      ST_WR_GO: state_s = ST_POLL;
      ST_POLL: begin
        // Done takes priority over reaching the poll limit in the same sample.
        if (bus_rd[1]) begin
          state_s = ST_RD_RES;
        end else begin
          cnt_s = cnt_inc_s;
          if (cnt_inc_s == CW'(TIMEOUT)) begin
            timeout_s = 1'b1;
            result_s  = {WIDTH{1'b0}};
            state_s   = ST_CLR_GO;
          end else begin
            state_s = ST_POLL;
          end
        end
      end
      ST_RD_RES: begin
        result_s = bus_rd;
        state_s  = ST_CLR_GO;
      end
      ST_CLR_GO: state_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Bus decode of the upcoming state, so the registered bus outputs track the state register.
  always_comb begin
    bus_we_s   = 1'b0;
    bus_addr_s = 2'd0;
    bus_wd_s   = {WIDTH{1'b0}};
    case (state_s)
      ST_WR_A: begin
        bus_we_s = 1'b1;
        bus_wd_s = op_a_s;
      end
      ST_WR_B: begin
        bus_we_s   = 1'b1;
        bus_addr_s = 2'd1;
        bus_wd_s   = op_b_s;
      end
      ST_WR_GO: begin
        bus_we_s   = 1'b1;
        bus_addr_s = 2'd2;
        bus_wd_s   = {{(WIDTH-1){1'b0}}, 1'b1};
      end
      ST_POLL:   bus_addr_s = 2'd2;
      ST_RD_RES: bus_addr_s = 2'd3;
      ST_CLR_GO: begin
        bus_we_s   = 1'b1;
        bus_addr_s = 2'd2;
      end
      default: begin
        bus_we_s   = 1'b0;
        bus_addr_s = 2'd0;
        bus_wd_s   = {WIDTH{1'b0}};
      end
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      op_a_r      <= {WIDTH{1'b0}};
      op_b_r      <= {WIDTH{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      timeout_r   <= 1'b0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 2'd0;
      bus_wd_r    <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      op_a_r      <= op_a_s;
      op_b_r      <= op_b_s;
      result_r    <= result_s;
      cnt_r       <= cnt_s;
      timeout_r   <= timeout_s;
      req_ready_r <= (state_s == ST_IDLE);
      busy_r      <= (state_s != ST_IDLE);
      rsp_valid_r <= (state_s == ST_RESP);
      bus_we_r    <= bus_we_s;
      bus_addr_r  <= bus_addr_s;
      bus_wd_r    <= bus_wd_s;
    end
  end

  assign req_ready   = req_ready_r;
  assign busy        = busy_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_result  = result_r;
  assign rsp_timeout = timeout_r;
  assign bus_we      = bus_we_r;
  assign bus_addr    = bus_addr_r;
  assign bus_wd      = bus_wd_r;

endmodule

// File: tb/tb_fpmul_bus_master.sv
// Self-checking bench: peripheral model on the bus, per-cycle behavioural checker and
// directed/random stimulus with hand-computed latency and result expectations.
module tb_fpmul_bus_master;

  localparam int TO = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_timeout;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wd;
  logic [31:0] bus_rd;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fpmul_bus_master #(.WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_timeout(rsp_timeout),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wd(bus_wd), .bus_rd(bus_rd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-operation peripheral behaviour: poll index at which done shows, and result override.
  int   op_done_at [128];
  logic op_ovr     [128];
  int   issued = 0;

  function automatic logic [31:0] prod_fn(input logic [31:0] a, input logic [31:0] b, input logic ovr);
    return ovr ? 32'h40C0_0000 : (a * 32'd3 + b);
  endfunction

  // ---------------- Peripheral model ----------------
  logic [31:0] pa = 32'd0, pb = 32'd0;
  logic        go = 1'b0;
  int          polls = 0;
  int          cur_done_at = 1;
  logic        cur_ovr = 1'b0;
  int          periph_ops = 0;
  logic        done_s;

  assign done_s = go && ((polls + 1) >= cur_done_at);

  always_comb begin
    case (bus_addr)
      2'd0:    bus_rd = pa;
      2'd1:    bus_rd = pb;
      2'd2:    bus_rd = {30'd0, done_s, go};
      default: bus_rd = prod_fn(pa, pb, cur_ovr);
    endcase
  end

  always @(posedge clk) begin
    if (bus_we) begin
      case (bus_addr)
        2'd0: pa <= bus_wd;
        2'd1: pb <= bus_wd;
        2'd2: begin
          go    <= bus_wd[0];
          polls <= 0;
          if (bus_wd[0]) begin
            cur_done_at <= op_done_at[periph_ops];
            cur_ovr     <= op_ovr[periph_ops];
            periph_ops  <= periph_ops + 1;
          end
        end
        default: ;
      endcase
    end else if (bus_addr == 2'd2) begin
      polls <= polls + 1;
    end
  end

  // ---------------- Behavioural model and per-cycle compare ----------------
  typedef struct packed {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
  } beat_t;

  beat_t       exp_q[$];
  int          phase = 0;      // 0 idle, 1 running bus sequence, 2 response pending
  logic [31:0] exp_res = 32'd0;
  logic        exp_to = 1'b0;
  int          model_ops = 0;
  int          resp_cnt = 0;

  function automatic void build(input logic [31:0] a, input logic [31:0] b, input int done_at, input logic ovr);
    int   npoll;
    logic timed;
    timed = (done_at > TO);
    npoll = timed ? TO : done_at;
    exp_q.push_back('{1'b1, 2'd0, a});
    exp_q.push_back('{1'b1, 2'd1, b});
    exp_q.push_back('{1'b1, 2'd2, 32'd1});
    for (int i = 0; i < npoll; i++) exp_q.push_back('{1'b0, 2'd2, 32'd0});
    if (!timed) exp_q.push_back('{1'b0, 2'd3, 32'd0});
    exp_q.push_back('{1'b1, 2'd2, 32'd0});
    exp_res = timed ? 32'd0 : prod_fn(a, b, ovr);
    exp_to  = timed;
  endfunction

  always @(negedge clk) begin
    beat_t bt;
    if (!rst) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_bus_we", bus_we, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_bus_wd", bus_wd, 0);
      phase = 0;
      exp_q.delete();
    end else begin
      case (phase)
        0: begin
          chk("idle_req_ready", req_ready, 1);
          chk("idle_busy", busy, 0);
          chk("idle_rsp_valid", rsp_valid, 0);
          chk("idle_bus", {bus_we, bus_addr, bus_wd}, 0);
          if (req_valid) begin
            build(req_a, req_b, op_done_at[model_ops], op_ovr[model_ops]);
            model_ops++;
            phase = 1;
          end
        end
        1: begin
          bt = exp_q.pop_front();
          chk("run_busy", busy, 1);
          chk("run_req_ready", req_ready, 0);
          chk("run_rsp_valid", rsp_valid, 0);
          chk("run_bus_we", bus_we, bt.we);
          chk("run_bus_addr", bus_addr, bt.addr);
          chk("run_bus_wd", bus_wd, bt.wd);
          if (exp_q.size() == 0) phase = 2;
        end
        default: begin
          chk("resp_valid", rsp_valid, 1);
          chk("resp_busy", busy, 1);
          chk("resp_req_ready", req_ready, 0);
          chk("resp_bus", {bus_we, bus_addr, bus_wd}, 0);
          chk("resp_result", rsp_result, exp_res);
          chk("resp_timeout", rsp_timeout, exp_to);
          if (rsp_ready) begin
            phase = 0;
            resp_cnt++;
          end
        end
      endcase
    end
  end

  // ---------------- Stimulus ----------------
  task automatic present(input logic [31:0] a, input logic [31:0] b, input int done_at, input logic ovr);
    int w;
    op_done_at[issued] = done_at;
    op_ovr[issued]     = ovr;
    issued++;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", req_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input int done_at, input logic ovr,
                      input int hold, input int exp_lat, input int exp_polls,
                      input logic [31:0] exp_r, input logic exp_t);
    int lat;
    int np;
    present(a, b, done_at, ovr);
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    lat = 1;
    np  = 0;
    while (lat < 300 && !rsp_valid) begin
      if (bus_addr == 2'd2 && !bus_we) np++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("poll_cycles", np, exp_polls);
    chk("lit_result", rsp_result, exp_r);
    chk("lit_timeout", rsp_timeout, exp_t);
    if (hold > 0) req_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_result", rsp_result, exp_r);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("back_to_idle", busy, 0);
  endtask

  initial begin
    int target;
    for (int i = 0; i < 128; i++) begin
      op_done_at[i] = 1;
      op_ovr[i]     = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    chk("init_req_ready", req_ready, 1);
    chk("init_busy", busy, 0);
    chk("init_rsp_result", rsp_result, 0);
    chk("init_rsp_timeout", rsp_timeout, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // 2.0 * 3.0 with done on the first poll
    send(32'h4000_0000, 32'h4040_0000, 1, 1'b1, 0, 7, 1, 32'h40C0_0000, 1'b0);
    // done on poll 20, response held for 10 cycles
    send(32'd1, 32'd2, 20, 1'b0, 10, 26, 20, 32'd5, 1'b0);
    // done never rises
    send(32'd7, 32'd9, 1000, 1'b0, 0, 29, TO, 32'd0, 1'b1);
    // done coincides with the poll limit
    send(32'd10, 32'd4, TO, 1'b0, 0, 30, TO, 32'd34, 1'b0);

    // reset mid-POLL
    present(32'h1234_5678, 32'h9ABC_DEF0, 1000, 1'b0);
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_result", rsp_result, 0);
    chk("mid_rst_rsp_timeout", rsp_timeout, 0);
    chk("mid_rst_bus", {bus_we, bus_addr, bus_wd}, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    send(32'd3, 32'd5, 2, 1'b0, 0, 8, 2, 32'd14, 1'b0);

    // back-to-back with rsp_ready tied high and random done delay
    target    = resp_cnt + 30;
    rsp_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      present($urandom, $urandom, 1 + int'($urandom_range(0, 8)), 1'b0);
    end
    req_valid = 1'b0;
    for (int w = 0; w < 500 && resp_cnt < target; w++) @(posedge clk);
    @(posedge clk);
    #1;
    chk("b2b_responses", resp_cnt, target);
    chk("b2b_idle", busy, 0);
    rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
